// File: rtl/pattern_det_sched_if.sv
// Detector-side bus of pattern_det_sched.
// The scheduler (master) drives det_rst, det_valid, det_in and det_pattern.
// The detector (slave) returns det_out.
// Handshake: det_valid/det_in is a one-way strobe with no ready. The detector
// takes det_in on every posedge where det_valid=1. It answers with det_out,
// registered, high for the cycle after the bit that completes a match.
// det_rst=1 clears the detector's history.
interface pattern_det_sched_if #(
    parameter int BITS = 8
);
    logic            det_rst;
    logic            det_valid;
    logic            det_in;
    logic [BITS-1:0] det_pattern;
    logic            det_out;

    modport master (
        output det_rst,
        output det_valid,
        output det_in,
        output det_pattern,
        input  det_out
    );

    modport slave (
        input  det_rst,
        input  det_valid,
        input  det_in,
        input  det_pattern,
        output det_out
    );
endinterface

// File: rtl/pattern_det_sched.sv
// pattern_det_sched: round-robin scheduler that lends one shared serial
// pattern detector to two requesters, one session at a time, and reports the
// match count of each session.
// Optional build macro PATTERN_DET_SCHED_TIMEOUT_EN adds an idle watchdog in
// RUN that aborts the session after TIMEOUT cycles without a valid bit.
// fsm_state exposes the controller state for observation.
module pattern_det_sched #(
    parameter int BITS    = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [BITS-1:0]  pat0,
    input  logic [BITS-1:0]  pat1,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic [1:0]       in_bit,
    input  logic [1:0]       in_vld,
    output logic [1:0]       gnt,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic             aborted,
    output logic [1:0]       fsm_state,
    pattern_det_sched_if.master det
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;

    // Session context captured at grant
    logic             gidx;       // granted requester
    logic             last;       // last granted requester (round-robin pointer)
    logic [BITS-1:0]  pat_q;
    logic [CNT_W-1:0] len_q;

    // Session progress
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] sess_cnt;
    logic             abort_q;

    // Result of the last completed session
    logic [CNT_W-1:0] match_q;
    logic             aborted_q;
    logic             done_id_q;

    // Combinational helpers
    logic             winner;
    logic             abort_n;
    logic             vld_g;
    logic             last_bit;
    logic             timeout_hit;

    // Saturating increment used by the match counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // Round-robin pick: on contention the requester not granted last wins
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11)
            winner = ~last;
        else
            winner = req[1];
    end

    // Stream path: only the granted requester reaches the detector, in RUN only
    always_comb begin
        vld_g         = in_vld[gidx];
        det.det_valid = (state == RUN) && vld_g;
        det.det_in    = (state == RUN) && in_bit[gidx];
        det.det_rst   = !rst || (state == LOAD);
        det.det_pattern = pat_q;
        last_bit      = det.det_valid && (bit_cnt == len_q - CNT_W'(1));
    end

`ifdef PATTERN_DET_SCHED_TIMEOUT_EN
    localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;

    // Watchdog: count consecutive RUN cycles without a valid bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if ((state == LOAD) || det.det_valid) begin
            idle_cnt <= '0;
        end else if ((state == RUN) && (idle_cnt != {IW{1'b1}})) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // This idle cycle is the TIMEOUT-th in a row
    assign timeout_hit = (state == RUN) && !det.det_valid &&
                         (idle_cnt == IW'(TIMEOUT - 1));
`else
    // No watchdog: RUN waits for bits indefinitely
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign timeout_hit        = 1'b0;
`endif

    // FSM next state; abort_n marks a transition into DONE that ends early
    always_comb begin
        state_n = state;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (|req)
                    state_n = LOAD;
            end
            LOAD: begin
                if (!req[gidx]) begin
                    state_n = DONE;
                    abort_n = 1'b1;
                end else if (len_q == '0) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!req[gidx]) begin
                    state_n = DONE;
                    abort_n = 1'b1;
                end else if (last_bit) begin
                    state_n = DONE;
                end else if (timeout_hit) begin
                    state_n = DONE;
                    abort_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Capture the winner's context on the IDLE->LOAD edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            gidx  <= 1'b0;
            last  <= 1'b1;
            pat_q <= '0;
            len_q <= '0;
        end else if ((state == IDLE) && (|req)) begin
            gidx  <= winner;
            last  <= winner;
            pat_q <= winner ? pat1 : pat0;
            len_q <= winner ? len1 : len0;
        end
    end

    // Bit and match counters of the session in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt  <= '0;
            sess_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    bit_cnt  <= '0;
                    sess_cnt <= '0;
                    abort_q  <= abort_n;
                end
                RUN: begin
                    if (det.det_valid)
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    sess_cnt <= sat_inc(sess_cnt, det.det_out);
                    abort_q  <= abort_n;
                end
                default: begin
                end
            endcase
        end
    end

    // Publish the session result at the end of DONE; a late det_out still counts
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_q   <= '0;
            aborted_q <= 1'b0;
            done_id_q <= 1'b0;
        end else if (state == DONE) begin
            match_q   <= sat_inc(sess_cnt, det.det_out);
            aborted_q <= abort_q;
            done_id_q <= gidx;
        end
    end

    // Client-facing outputs
    always_comb begin
        gnt       = 2'b00;
        if (state != IDLE)
            gnt = gidx ? 2'b10 : 2'b01;
        done      = (state == DONE);
        done_id   = (state == DONE) ? gidx : done_id_q;
        match_cnt = match_q;
        aborted   = aborted_q;
        fsm_state = state;
    end

endmodule

// File: tb/tb_pattern_det_sched.sv
// Bench for pattern_det_sched: directed scenarios plus randomized sessions.
// A behavioural detector answers on det_out. Expected match counts are
// computed by scanning the recorded stream of each session for the pattern.
module tb_pattern_det_sched;

    localparam int BITS    = 8;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [BITS-1:0]  pat0, pat1;
    logic [CNT_W-1:0] len0, len1;
    logic [1:0]       in_bit, in_vld;
    logic [1:0]       gnt;
    logic             done, done_id, aborted;
    logic [CNT_W-1:0] match_cnt;
    logic [1:0]       fsm_state;

    pattern_det_sched_if #(.BITS(BITS)) det_bus ();

    pattern_det_sched #(.BITS(BITS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req),
        .pat0(pat0), .pat1(pat1), .len0(len0), .len1(len1),
        .in_bit(in_bit), .in_vld(in_vld), .gnt(gnt),
        .done(done), .done_id(done_id), .match_cnt(match_cnt),
        .aborted(aborted), .fsm_state(fsm_state), .det(det_bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Behavioural detector: history of the last BITS valid bits, flag next cycle
    logic [BITS-1:0] dsh;
    int              dfill;
    always @(posedge clk) begin
        if (det_bus.det_rst) begin
            dsh <= '0;
            dfill <= 0;
            det_bus.det_out <= 1'b0;
        end else if (det_bus.det_valid) begin
            dsh <= {dsh[BITS-2:0], det_bus.det_in};
            if (dfill < BITS) dfill <= dfill + 1;
            det_bus.det_out <= (dfill >= BITS - 1) &&
                               ({dsh[BITS-2:0], det_bus.det_in} == det_bus.det_pattern);
        end else begin
            det_bus.det_out <= 1'b0;
        end
    end

    // scoreboard
    int   checks = 0;
    int   errors = 0;
    logic bit_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of windows of BITS consecutive stream bits equal to p
    function automatic int count_matches(input logic [BITS-1:0] p);
        int n;
        logic [BITS-1:0] w;
        n = 0;
        for (int i = BITS - 1; i < bit_q.size(); i++) begin
            w = '0;
            for (int j = i - BITS + 1; j <= i; j++) w = {w[BITS-2:0], bit_q[j]};
            if (w == p) n++;
        end
        if (n > (2 ** CNT_W) - 1) n = (2 ** CNT_W) - 1;
        return n;
    endfunction

    // driver: raise req for r and follow the grant into LOAD
    task automatic start_session(input int r, input logic [BITS-1:0] p, input int len);
        int waitc;
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        if (r == 0) begin pat0 = p; len0 = CNT_W'(len); end
        else        begin pat1 = p; len1 = CNT_W'(len); end
        req[r] = 1'b1;
        in_vld = 2'b00;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (gnt == 2'b00 && waitc < 20);
        chk("grant", 32'(gnt), 32'(oh));
        chk("load_det_rst", 32'(det_bus.det_rst), 32'd1);
        chk("load_det_valid", 32'(det_bus.det_valid), 32'd0);
        chk("load_pattern", 32'(det_bus.det_pattern), 32'(p));
    endtask

    // one full session; abort_at<0 means no abort, fixed streams MSB first
    task automatic run_session(input int r, input logic [BITS-1:0] p, input int len,
                               input int abort_at, input int vld_pct,
                               input bit use_fixed, input logic [31:0] fixed_bits);
        int sent;
        int exp_m;
        logic exp_ab;
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        bit_q.delete();
        start_session(r, p, len);
        sent = 0;
        if (abort_at == 0) begin
            req[r] = 1'b0;
        end else if (len > 0) begin
            while (sent < len && sent != abort_at) begin
                @(negedge clk);
                chk("run_no_done", 32'(done), 32'd0);
                in_vld[r]     = ($urandom_range(99) < vld_pct);
                in_vld[1 - r] = 1'($urandom_range(1));
                in_bit        = 2'($urandom_range(3));
                if (use_fixed) in_bit[r] = fixed_bits[len - 1 - sent];
                #1;
                chk("mirror_valid", 32'(det_bus.det_valid), 32'(in_vld[r]));
                chk("mirror_in", 32'(det_bus.det_in), 32'(in_bit[r]));
                if (in_vld[r]) begin
                    bit_q.push_back(in_bit[r]);
                    sent++;
                end
            end
            if (sent == abort_at) begin
                @(negedge clk);
                chk("pre_abort_no_done", 32'(done), 32'd0);
                req[r] = 1'b0;
                in_vld = 2'b00;
            end
        end
        exp_m  = count_matches(p);
        exp_ab = (abort_at >= 0) && (abort_at < len);
        @(negedge clk);
        in_vld = 2'b00;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_id", 32'(done_id), 32'(r));
        chk("done_gnt", 32'(gnt), 32'(oh));
        chk("done_det_valid", 32'(det_bus.det_valid), 32'd0);
        req[r] = 1'b0;
        @(negedge clk);
        chk("gap_gnt", 32'(gnt), 32'd0);
        chk("gap_done", 32'(done), 32'd0);
        chk("match_cnt", 32'(match_cnt), 32'(exp_m));
        chk("aborted", 32'(aborted), 32'(exp_ab));
        chk("idle_det_rst", 32'(det_bus.det_rst), 32'd0);
    endtask

    initial begin
        int len, ab, idle;
        logic [1:0] exp_g;

        rst = 1'b0; req = 2'b00; pat0 = '0; pat1 = '0; len0 = '0; len1 = '0;
        in_bit = 2'b00; in_vld = 2'b00;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_det_rst", 32'(det_bus.det_rst), 32'd1);
        chk("rst_det_valid", 32'(det_bus.det_valid), 32'd0);
        chk("rst_det_in", 32'(det_bus.det_in), 32'd0);
        chk("rst_pattern", 32'(det_bus.det_pattern), 32'd0);
        chk("rst_match", 32'(match_cnt), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst = 1'b1;

        // zero-length session: LOAD then DONE, nothing counted
        run_session(1, 8'h3C, 0, -1, 100, 1'b0, 32'h0);

        // single A5 occurrence in a 16-bit stream
        run_session(0, 8'hA5, 16, -1, 100, 1'b1, 32'h0000_00A5);
        chk("a5_match_cnt", 32'(match_cnt), 32'd1);

        // reset for one cycle in the middle of RUN
        start_session(0, 8'h5A, 20);
        repeat (4) begin
            @(negedge clk);
            in_vld = 2'b01;
            in_bit = 2'($urandom_range(3));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_det_rst", 32'(det_bus.det_rst), 32'd1);
        @(negedge clk);
        req = 2'b00; in_vld = 2'b00;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_match", 32'(match_cnt), 32'd0);
        chk("midrst_aborted", 32'(aborted), 32'd0);
        chk("midrst_pattern", 32'(det_bus.det_pattern), 32'd0);
        chk("midrst_det_valid", 32'(det_bus.det_valid), 32'd0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end

        // both requesting from reset: 0, 1, 0 with one idle cycle between
        len0 = 8'd4; len1 = 8'd4; req = 2'b11; in_vld = 2'b11;
        idle = 0;
        do begin
            @(negedge clk);
            idle++;
        end while (gnt == 2'b00 && idle < 20);
        for (int k = 0; k < 21; k++) begin
            exp_g = ((k % 7) == 6) ? 2'b00 : ((((k / 7) % 2) == 0) ? 2'b01 : 2'b10);
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            if ((k % 7) == 5) chk("rr_done", 32'(done), 32'd1);
            in_bit = 2'($urandom_range(3));
            if (k == 20) begin req = 2'b00; in_vld = 2'b00; end
            @(negedge clk);
        end

        // requester drops after 3 of 10 bits
        run_session(0, 8'($urandom), 10, 3, 100, 1'b0, 32'h0);
        // drop during LOAD, and a one-bit session
        run_session(1, 8'($urandom), 5, 0, 100, 1'b0, 32'h0);
        run_session(0, 8'($urandom), 1, -1, 100, 1'b0, 32'h0);

        // randomized sessions, low-entropy patterns to make matches likely
        for (int s = 0; s < 16; s++) begin
            len = $urandom_range(24);
            ab  = (len > 0 && $urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
            run_session($urandom_range(1), ($urandom_range(1) == 1) ? 8'hFF : 8'h55 ^ 8'($urandom_range(3)),
                        len, ab, $urandom_range(100, 70), 1'b0, 32'h0);
        end

        // stalled stream in RUN
        start_session(0, 8'h81, 10);
        repeat (2) begin
            @(negedge clk);
            in_vld = 2'b01;
            in_bit = 2'($urandom_range(3));
        end
        idle = 0;
`ifdef PATTERN_DET_SCHED_TIMEOUT_EN
        @(negedge clk);
        in_vld = 2'b00;
        while (!done && idle < 40) begin
            idle++;
            @(negedge clk);
        end
        chk("timeout_idle_cycles", 32'(idle), 32'(TIMEOUT));
        chk("timeout_done", 32'(done), 32'd1);
        req = 2'b00;
        @(negedge clk);
        chk("timeout_aborted", 32'(aborted), 32'd1);
`else
        repeat (40) begin
            @(negedge clk);
            in_vld = 2'b00;
            if (done) idle++;
        end
        chk("no_timeout_done", 32'(idle), 32'd0);
        req = 2'b00;
        @(negedge clk);
        chk("stall_drop_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("stall_drop_aborted", 32'(aborted), 32'd1);
`endif

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_det_sched.md
PATTERN_DET_SCHED -- requirements
Module: pattern_det_sched

Interface
REQ-001 SHALL have parameter BITS, default 8, pattern width passed to the dyn_pattern_imp detector.
REQ-002 SHALL have parameter CNT_W, default 8, width of session length and match count.
REQ-003 SHALL have parameter TIMEOUT, default 16, idle-cycle limit for the watchdog (see Configuration).
REQ-004 clk  input  1  single clock, all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req  input  2  session request per requester (bit i = requester i), level, held for the whole session.
REQ-007 pat0, pat1  input  BITS  pattern of requester 0 / 1, sampled at grant.
REQ-008 len0, len1  input  CNT_W  session length in stream bits of requester 0 / 1, sampled at grant.
REQ-009 in_bit  input  2  serial stream bit per requester.
REQ-010 in_vld  input  2  stream-bit valid per requester.
REQ-011 gnt  output  2  one-hot grant, high from LOAD through DONE.
REQ-012 det_rst  output  1  detector reset, active-high.
REQ-013 det_valid, det_in  output  1 each  detector stream valid and data.
REQ-014 det_pattern  output  BITS  detector pattern.
REQ-015 det_out  input  1  detector match flag, registered, high the cycle after the completing bit.
REQ-016 done  output  1  one-cycle session-complete pulse.
REQ-017 done_id  output  1  requester that owned the completed session.
REQ-018 match_cnt  output  CNT_W  matches of the completed session, held until the next done.
REQ-019 aborted  output  1  qualifies done: the session ended early, held with match_cnt.

Function
REQ-020 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-021 IDLE: with any req bit high, SHALL go to LOAD and set gnt to the winner, latching the winner's pat and len.
REQ-022 Arbitration SHALL be round-robin: when both requesters request, the one not granted last wins; after reset requester 0 has priority.
REQ-023 LOAD SHALL last exactly 1 cycle, with det_rst=1, det_valid=0 and det_pattern=latched pattern; det_pattern SHALL hold that value until the next LOAD.
REQ-024 LOAD SHALL go to RUN when the latched len>0, and to DONE with match_cnt=0 when len==0.
REQ-025 RUN: det_valid and det_in SHALL combinationally mirror in_vld and in_bit of the granted requester; in_vld of the non-granted requester SHALL be ignored.
REQ-026 RUN: a CNT_W-bit bit counter SHALL increment on each det_valid; the bit with count==len-1 SHALL move the block to DONE on the next edge.
REQ-027 The session match counter SHALL increment when det_out=1 in RUN or DONE, saturate at 2^CNT_W-1, and clear in LOAD.
REQ-028 DONE SHALL last 1 cycle, with det_valid=0, done=1, done_id=granted index, and match_cnt/aborted updated at the end of DONE; it SHALL then go to IDLE with gnt=0.
REQ-029 When the granted req drops in LOAD or RUN, the block SHALL go to DONE with aborted=1; a det_out arriving in that DONE cycle SHALL still be counted.
REQ-030 IDLE->LOAD SHALL be the earliest re-grant after DONE, giving a minimum 1-cycle gap with gnt=0 between sessions.
REQ-031 A req edge arriving during a session SHALL wait; it is not lost while held.

Reset
REQ-032 With rst=0 at a posedge, the block SHALL enter IDLE with gnt=0, det_valid=0, det_in=0, det_pattern=0, done=0, done_id=0, match_cnt=0, aborted=0, and the round-robin pointer favouring requester 0.
REQ-033 det_rst SHALL be 1 throughout controller reset and in LOAD, and 0 otherwise.
REQ-034 Reset mid-session SHALL drop the session without a done pulse.

Configuration
REQ-035 Macro PATTERN_DET_SCHED_TIMEOUT_EN defined: in RUN, TIMEOUT consecutive cycles with det_valid=0 SHALL force DONE with aborted=1, and the idle counter SHALL clear on each det_valid and in LOAD.
REQ-036 Macro PATTERN_DET_SCHED_TIMEOUT_EN undefined: no watchdog logic SHALL exist, and RUN SHALL wait indefinitely.

Verification
REQ-037 Scenario: req=01, pat0=8'hA5, len0=16, stream containing A5 once -> gnt=01, det_rst 1 cycle, done pulse after the 16th bit with done_id=0, match_cnt=1, aborted=0.
REQ-038 Scenario: req=11 from reset, len0=len1=4 -> requester 0 is served, then requester 1, then requester 0 again, with a 1-cycle gnt=0 gap each time.
REQ-039 Scenario: req0 drops after 3 of len0=10 bits -> done=1, aborted=1, match_cnt is the count so far.
REQ-040 Scenario: len1=0 -> LOAD then DONE, match_cnt=0, aborted=0.
REQ-041 Scenario: with TIMEOUT_EN defined and TIMEOUT=16, in_vld held 0 in RUN -> done with aborted=1 exactly 16 cycles after the last valid; with the macro undefined -> no done.
REQ-042 Scenario: rst=0 mid-RUN for 1 cycle -> all outputs at reset values, det_rst=1, no done pulse.
